// File: rtl/uart_pkg.sv
// Shared constants and state types for the memory-mapped UART.
package uart_pkg;

    localparam int OVERSAMPLE = 16;

    localparam logic [7:0] TXDATA_ADDR  = 8'h00;
    localparam logic [7:0] RXDATA_ADDR  = 8'h04;
    localparam logic [7:0] STATUS_ADDR  = 8'h08;
    localparam logic [7:0] CTRL_ADDR    = 8'h0C;
    localparam logic [7:0] BAUDDIV_ADDR = 8'h10;
    localparam logic [7:0] INTSTAT_ADDR = 8'h14;

    localparam int ST_TX_BUSY   = 0;
    localparam int ST_RX_VALID  = 1;
    localparam int ST_RX_OVR    = 2;
    localparam int ST_FRAME_ERR = 3;
    localparam int ST_PAR_ERR   = 4;

    localparam int CT_TX_EN     = 0;
    localparam int CT_RX_EN     = 1;
    localparam int CT_TXDONE_IE = 2;
    localparam int CT_RXDONE_IE = 3;
    localparam int CT_PAR_EN    = 4;

    localparam int IS_TX_DONE = 0;
    localparam int IS_RX_DONE = 1;

    typedef enum logic [2:0] {
        TX_IDLE, TX_START, TX_DATA, TX_PAR, TX_STOP
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE, RX_START, RX_DATA, RX_PAR, RX_STOP
    } rx_state_t;

endpackage

// File: rtl/uart_baud_gen.sv
// Oversample tick generator: one-cycle tick every div+1 clocks.
module uart_baud_gen (
    input  logic        clk,
    input  logic        resetn,
    input  logic        restart,
    input  logic [15:0] div,
    output logic        tick
);

    logic [15:0] cnt;

    assign tick = (cnt == div);

    always_ff @(posedge clk) begin
        if (resetn || restart) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 16'd1;
        end
    end

endmodule

// File: rtl/uart_apb_subsystem.sv
// Memory-mapped 8N1 UART: register file, TX/RX engines and level IRQ.
// Define UART_PARITY_EN for optional even-parity (8E1) framing.
module uart_apb_subsystem
    import uart_pkg::*;
#(
    parameter logic [15:0] DEFAULT_DIV = 16'd7,
    parameter int          ADDR_W      = 32
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              transfer,
    input  logic              write_read,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    output logic              tx,
    input  logic              rx,
    output logic              IRQ
);

`ifdef UART_PARITY_EN
    localparam logic [4:0] CTRL_MASK = 5'h1F;
`else
    localparam logic [4:0] CTRL_MASK = 5'h0F;
`endif
    localparam logic [3:0] LAST = 4'(OVERSAMPLE - 1);
    localparam logic [3:0] HALF = 4'(OVERSAMPLE / 2 - 1);

    logic [7:0]  reg_addr;
    logic        wr, rd;
    logic        sel_tx, sel_rx, sel_st, sel_ct, sel_bd, sel_is;
    logic [4:0]  ctrl;
    logic [15:0] bauddiv;
    logic [7:0]  rxdata;
    logic        rx_valid, rx_overrun, frame_err, par_err;
    logic        tx_done, rx_done;
    logic        tick, tx_en, rx_en, par_en, tx_busy;
    logic        tx_fin, rx_fin, ferr_set, perr_set;
    logic [31:0] rd_mux;
    logic        unused_bits;

    tx_state_t   tx_state;
    logic [3:0]  tx_cnt;
    logic [2:0]  tx_bit;
    logic [7:0]  tx_shift;
    logic        tx_par;

    rx_state_t   rx_state;
    logic [3:0]  rx_cnt;
    logic [2:0]  rx_bit;
    logic [7:0]  rx_shift;
    logic        rx_s1, rx_s2, rx_s3;

    assign reg_addr = addr[7:0];
    assign wr       = transfer & write_read;
    assign rd       = transfer & ~write_read;
    assign sel_tx   = reg_addr == TXDATA_ADDR;
    assign sel_rx   = reg_addr == RXDATA_ADDR;
    assign sel_st   = reg_addr == STATUS_ADDR;
    assign sel_ct   = reg_addr == CTRL_ADDR;
    assign sel_bd   = reg_addr == BAUDDIV_ADDR;
    assign sel_is   = reg_addr == INTSTAT_ADDR;
    assign unused_bits = ^{addr[ADDR_W-1:8], wdata[31:16]};

    assign tx_en    = ctrl[CT_TX_EN];
    assign rx_en    = ctrl[CT_RX_EN];
    assign par_en   = ctrl[CT_PAR_EN];
    assign tx_busy  = tx_state != TX_IDLE;
    assign tx_fin   = tick && tx_state == TX_STOP && tx_cnt == LAST;
    assign rx_fin   = rx_en && tick && rx_state == RX_STOP && rx_cnt == LAST;
    assign ferr_set = rx_fin && !rx_s2;
    assign perr_set = rx_en && tick && rx_state == RX_PAR
                      && rx_cnt == LAST && (rx_s2 != ^rx_shift);

    uart_baud_gen u_baud (
        .clk     (clk),
        .resetn  (resetn),
        .restart (wr & sel_bd),
        .div     (bauddiv),
        .tick    (tick)
    );

    always_comb begin
        rd_mux = '0;
        unique case (1'b1)
            sel_rx:  rd_mux = {24'd0, rxdata};
            sel_st:  rd_mux = {27'd0, par_err, frame_err, rx_overrun,
                               rx_valid, tx_busy};
            sel_ct:  rd_mux = {27'd0, ctrl};
            sel_bd:  rd_mux = {16'd0, bauddiv};
            sel_is:  rd_mux = {30'd0, rx_done, tx_done};
            default: rd_mux = '0;
        endcase
    end

    // Hardware set terms sit outside the clear terms so a same-edge set wins
    always_ff @(posedge clk) begin
        if (resetn) begin
            ctrl       <= '0;
            bauddiv    <= DEFAULT_DIV;
            rxdata     <= '0;
            rx_valid   <= 1'b0;
            rx_overrun <= 1'b0;
            frame_err  <= 1'b0;
            par_err    <= 1'b0;
            tx_done    <= 1'b0;
            rx_done    <= 1'b0;
            rdata      <= '0;
            IRQ        <= 1'b0;
        end else begin
            if (wr && sel_ct) ctrl <= wdata[4:0] & CTRL_MASK;
            if (wr && sel_bd) bauddiv <= wdata[15:0];
            if (rx_fin) rxdata <= rx_shift;
            if (rd) rdata <= rd_mux;
            rx_valid   <= rx_fin | (rx_valid & ~(rd & sel_rx));
            rx_overrun <= (rx_fin & rx_valid)
                        | (rx_overrun & ~(wr & sel_st & wdata[ST_RX_OVR]));
            frame_err  <= ferr_set
                        | (frame_err & ~(wr & sel_st & wdata[ST_FRAME_ERR]));
            par_err    <= perr_set
                        | (par_err & ~(wr & sel_st & wdata[ST_PAR_ERR]));
            tx_done    <= tx_fin
                        | (tx_done & ~(wr & sel_is & wdata[IS_TX_DONE]));
            rx_done    <= rx_fin
                        | (rx_done & ~(wr & sel_is & wdata[IS_RX_DONE]));
            IRQ        <= (tx_done & ctrl[CT_TXDONE_IE])
                        | (rx_done & ctrl[CT_RXDONE_IE]);
        end
    end

    always_ff @(posedge clk) begin
        if (resetn) begin
            tx_state <= TX_IDLE;
            tx       <= 1'b1;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_shift <= '0;
            tx_par   <= 1'b0;
        end else if (tx_state == TX_IDLE) begin
            if (wr && sel_tx && tx_en) begin
                tx_state <= TX_START;
                tx       <= 1'b0;
                tx_shift <= wdata[7:0];
                tx_par   <= ^wdata[7:0];
                tx_cnt   <= '0;
                tx_bit   <= '0;
            end
        end else if (tick) begin
            tx_cnt <= tx_cnt + 4'd1;
            if (tx_cnt == LAST) begin
                unique case (tx_state)
                    TX_START: begin
                        tx_state <= TX_DATA;
                        tx       <= tx_shift[0];
                    end
                    TX_DATA: begin
                        tx_bit   <= tx_bit + 3'd1;
                        tx_shift <= {1'b0, tx_shift[7:1]};
                        if (tx_bit != 3'd7) begin
                            tx <= tx_shift[1];
                        end else if (par_en) begin
                            tx_state <= TX_PAR;
                            tx       <= tx_par;
                        end else begin
                            tx_state <= TX_STOP;
                            tx       <= 1'b1;
                        end
                    end
                    TX_PAR: begin
                        tx_state <= TX_STOP;
                        tx       <= 1'b1;
                    end
                    default: tx_state <= TX_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (resetn) begin
            rx_s1    <= 1'b1;
            rx_s2    <= 1'b1;
            rx_s3    <= 1'b1;
            rx_state <= RX_IDLE;
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_shift <= '0;
        end else begin
            rx_s1 <= rx;
            rx_s2 <= rx_s1;
            rx_s3 <= rx_s2;
            if (!rx_en) begin
                rx_state <= RX_IDLE;
            end else if (rx_state == RX_IDLE) begin
                if (rx_s3 && !rx_s2) begin
                    rx_state <= RX_START;
                    rx_cnt   <= '0;
                    rx_bit   <= '0;
                end
            end else if (tick) begin
                rx_cnt <= rx_cnt + 4'd1;
                unique case (rx_state)
                    RX_START: begin
                        // Mid-start check rejects short glitches
                        if (rx_cnt == HALF) begin
                            rx_cnt   <= '0;
                            rx_state <= rx_s2 ? RX_IDLE : RX_DATA;
                        end
                    end
                    RX_DATA: begin
                        if (rx_cnt == LAST) begin
                            rx_shift <= {rx_s2, rx_shift[7:1]};
                            rx_bit   <= rx_bit + 3'd1;
                            if (rx_bit == 3'd7) begin
                                rx_state <= par_en ? RX_PAR : RX_STOP;
                            end
                        end
                    end
                    RX_PAR: begin
                        if (rx_cnt == LAST) rx_state <= RX_STOP;
                    end
                    default: begin
                        if (rx_cnt == LAST) rx_state <= RX_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_apb_subsystem.sv
// Loopback bench for uart_apb_subsystem with a queue-based byte model.
module tb_uart_apb_subsystem;
    import uart_pkg::*;

`ifdef UART_PARITY_EN
    localparam logic [31:0] CTRL_MASK = 32'h1F;
`else
    localparam logic [31:0] CTRL_MASK = 32'h0F;
`endif

    logic        clk = 1'b0;
    logic        resetn = 1'b1;
    logic        transfer = 1'b0;
    logic        write_read = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic        tx, rx, IRQ;
    logic        force_en = 1'b0;
    logic        force_val = 1'b1;

    int n_checks = 0;
    int n_pass = 0;
    int cyc = 0;
    int wr_edge = 0;
    int rd_edge = 0;
    int tx_edge = 0;
    logic [7:0] exp_q[$];

    assign rx = force_en ? force_val : tx;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_apb_subsystem dut (
        .clk        (clk),
        .resetn     (resetn),
        .transfer   (transfer),
        .write_read (write_read),
        .addr       (addr),
        .wdata      (wdata),
        .rdata      (rdata),
        .tx         (tx),
        .rx         (rx),
        .IRQ        (IRQ)
    );

    initial begin
        repeat (90000) @(posedge clk);
        $display("FAIL watchdog: got %0d cycles expected fewer", cyc);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic bus_write(input logic [7:0] a, input logic [31:0] d);
        @(negedge clk);
        transfer   = 1'b1;
        write_read = 1'b1;
        addr       = {24'($urandom), a};
        wdata      = d;
        @(posedge clk);
        wr_edge = cyc;
        @(negedge clk);
        transfer   = 1'b0;
        write_read = 1'b0;
    endtask

    task automatic bus_read(input logic [7:0] a, output logic [31:0] d);
        @(negedge clk);
        transfer   = 1'b1;
        write_read = 1'b0;
        addr       = {24'($urandom), a};
        @(posedge clk);
        rd_edge = cyc;
        @(negedge clk);
        transfer = 1'b0;
        d = rdata;
    endtask

    task automatic start_tx(input logic [7:0] b, input int d);
        bus_write(BAUDDIV_ADDR, d);
        bus_write(TXDATA_ADDR, {24'd0, b});
        tx_edge = wr_edge;
        exp_q.push_back(b);
    endtask

    // Busy lasts 160 ticks; first tick lands 1..d+1 cycles after accept
    task automatic wait_tx(input int d);
        logic [31:0] s;
        bit done;
        int m;
        done = 1'b0;
        s = '0;
        for (int i = 0; i < 3000 && !done; i++) begin
            bus_read(STATUS_ADDR, s);
            done = !s[ST_TX_BUSY];
        end
        m = rd_edge - tx_edge;
        check("tx_idle", {31'd0, done}, 32'd1);
        check("busy_len",
              {31'd0, (m >= 159 * (d + 1) + 2 && m <= 160 * (d + 1) + 2)},
              32'd1);
    endtask

    task automatic check_rx(input string tag);
        logic [31:0] r;
        logic [31:0] st;
        logic [31:0] exp_st;
        exp_st = (exp_q.size() > 0 ? 32'h2 : 32'h0)
               | (exp_q.size() > 1 ? 32'h4 : 32'h0);
        bus_read(STATUS_ADDR, st);
        check({tag, "_status"}, st, exp_st);
        while (exp_q.size() > 1) void'(exp_q.pop_front());
        bus_read(RXDATA_ADDR, r);
        check({tag, "_data"}, r, (exp_q.size() > 0) ? {24'd0, exp_q[0]} : 32'd0);
        if (exp_q.size() > 0) void'(exp_q.pop_front());
    endtask

    initial begin
        logic [31:0] r, v, bd;
        logic [7:0]  b;
        int          d;

        repeat (2) @(posedge clk);
        @(negedge clk);
        resetn = 1'b0;
        check("rst_tx", {31'd0, tx}, 32'd1);
        check("rst_irq", {31'd0, IRQ}, 32'd0);
        check("rst_rdata", rdata, 32'd0);
        bus_read(STATUS_ADDR, r);  check("rst_status", r, 32'd0);
        bus_read(CTRL_ADDR, r);    check("rst_ctrl", r, 32'd0);
        bus_read(BAUDDIV_ADDR, r); check("rst_baud", r, 32'd7);
        bus_read(INTSTAT_ADDR, r); check("rst_intstat", r, 32'd0);
        bus_read(RXDATA_ADDR, r);  check("rst_rxdata", r, 32'd0);
        bus_read(8'h40, r);        check("unmapped_rd", r, 32'd0);

        for (int i = 0; i < 4; i++) begin
            v = $urandom;
            bus_write(CTRL_ADDR, v);
            bus_read(CTRL_ADDR, r);
            check("ctrl_rw", r, v & CTRL_MASK);
            bd = $urandom;
            bus_write(BAUDDIV_ADDR, bd);
            bus_read(BAUDDIV_ADDR, r);
            check("baud_rw", r, bd & 32'hFFFF);
            bus_write(8'h1C, $urandom);
            bus_read(BAUDDIV_ADDR, r);
            check("unmapped_wr", r, bd & 32'hFFFF);
        end

        bus_write(CTRL_ADDR, 32'hF);
        start_tx(8'hA5, 7);
        wait_tx(7);
        check("irq_set", {31'd0, IRQ}, 32'd1);
        bus_read(INTSTAT_ADDR, r); check("intstat_both", r, 32'h3);
        check_rx("lb_a5");
        bus_read(STATUS_ADDR, r);  check("rx_valid_clr", r, 32'd0);
        bus_write(INTSTAT_ADDR, 32'h3);
        @(negedge clk);
        check("irq_clr", {31'd0, IRQ}, 32'd0);
        bus_read(INTSTAT_ADDR, r); check("intstat_w1c", r, 32'd0);

        start_tx(8'h5A, 7);
        bus_write(TXDATA_ADDR, 32'hC3);
        wait_tx(7);
        check_rx("busy_drop");
        bus_write(INTSTAT_ADDR, 32'h3);
        repeat (1500) @(negedge clk);
        bus_read(INTSTAT_ADDR, r); check("no_second_frame", r, 32'd0);

        start_tx(8'h11, 7);
        wait_tx(7);
        start_tx(8'h22, 7);
        wait_tx(7);
        check_rx("overrun");
        bus_write(STATUS_ADDR, 32'h4);
        bus_read(STATUS_ADDR, r);  check("overrun_w1c", r, 32'd0);

        for (int i = 0; i < 5; i++) begin
            b = 8'($urandom);
            d = $urandom_range(0, 3);
            start_tx(b, d);
            wait_tx(d);
            check_rx("lb_rand");
        end
        start_tx(8'h3C, 0);
        wait_tx(0);
        check_rx("lb_div0");

        bus_write(BAUDDIV_ADDR, 32'd7);
        bus_write(CTRL_ADDR, 32'h3);
        bus_write(INTSTAT_ADDR, 32'h3);
        force_en  = 1'b1;
        force_val = 1'b0;
        repeat (1400) @(negedge clk);
        force_val = 1'b1;
        repeat (20) @(negedge clk);
        force_en = 1'b0;
        check("irq_masked", {31'd0, IRQ}, 32'd0);
        bus_read(INTSTAT_ADDR, r); check("ferr_intstat", r, 32'h2);
        bus_read(STATUS_ADDR, r);  check("ferr_status", r, 32'hA);
        bus_read(RXDATA_ADDR, r);  check("ferr_data", r, 32'd0);
        bus_write(STATUS_ADDR, 32'h8);
        bus_read(STATUS_ADDR, r);  check("ferr_w1c", r, 32'd0);

        bus_write(INTSTAT_ADDR, 32'h3);
        force_en  = 1'b1;
        force_val = 1'b0;
        repeat (3) @(negedge clk);
        force_en = 1'b0;
        repeat (1500) @(negedge clk);
        bus_read(INTSTAT_ADDR, r); check("glitch_intstat", r, 32'd0);
        bus_read(STATUS_ADDR, r);  check("glitch_status", r, 32'd0);

        bus_write(CTRL_ADDR, 32'h1);
        bus_write(TXDATA_ADDR, 32'h00);
        repeat (300) @(negedge clk);
        check("tx_mid_frame", {31'd0, tx}, 32'd0);
        resetn = 1'b1;
        @(posedge clk);
        #1;
        check("tx_after_rst", {31'd0, tx}, 32'd1);
        @(negedge clk);
        resetn = 1'b0;
        bus_read(BAUDDIV_ADDR, r); check("rst2_baud", r, 32'd7);
        bus_read(STATUS_ADDR, r);  check("rst2_status", r, 32'd0);
        bus_read(CTRL_ADDR, r);    check("rst2_ctrl", r, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
